fpnew_slice_arbiter: RTL
========================

FPNEW_SLICE_ARBITER -- requirements
Module: fpnew_slice_arbiter

Interface
REQ-001 Parameter NumReq, default 4, number of requesters sharing one opgroup format slice.
REQ-002 Parameter Width, default 32, operand/result width of the shared slice.
REQ-003 Parameter NumOperands, default 3, operands per operation.
REQ-004 Parameter IdDepth, default 4, maximum operations in flight (ID FIFO depth, power of two, >=2).
REQ-005 clk_i  input  1  single clock; all state on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  input  NumReq  per-requester operation valid.
REQ-008 req_ready_o  output  NumReq  per-requester accept.
REQ-009 req_operands_i  input  NumReq*NumOperands*Width  packed operands, requester r at slice r.
REQ-010 req_op_i  input  NumReq*4  fpnew_pkg::operation_e per requester.
REQ-011 req_rnd_mode_i  input  NumReq*3  fpnew_pkg::roundmode_e per requester.
REQ-012 slc_valid_o / slc_ready_i  output/input  1/1  issue handshake to slice.
REQ-013 slc_operands_o, slc_op_o, slc_rnd_mode_o  output  NumOperands*Width, 4, 3  granted request payload.
REQ-014 slc_out_valid_i / slc_out_ready_o  input/output  1/1  slice result handshake.
REQ-015 slc_result_i, slc_status_i  input  Width, 5  slice result and fpnew_pkg::status_t.
REQ-016 rsp_valid_o / rsp_ready_i  output/input  NumReq/NumReq  per-requester response handshake.
REQ-017 rsp_result_o, rsp_status_o  output  Width, 5  shared response payload, valid for the flagged requester.
REQ-018 flush_i  input  1  discard all tracking state.
REQ-019 busy_o  output  1  high while any operation is in flight or any grant is locked.

Function
REQ-020 Arbitration SHALL be round-robin: search starts at rr_ptr, first requester with req_valid_i set wins.
REQ-021 Once slc_valid_o rises, the granted index SHALL be locked until slc_valid_o & slc_ready_i; payload stable while locked.
REQ-022 slc_valid_o SHALL be 0 when ID FIFO full, even if a pop occurs the same cycle.
REQ-023 req_ready_o[g] SHALL equal slc_ready_i & slc_valid_o for granted g only; all other bits 0.
REQ-024 On issue handshake: push g into ID FIFO, rr_ptr <= (g+1) mod NumReq, release lock.
REQ-025 Slice returns results in issue order; head of ID FIFO SHALL identify the owner.
REQ-026 rsp_valid_o[head] SHALL equal slc_out_valid_i & FIFO non-empty; other bits 0; result/status passed combinationally.
REQ-027 slc_out_ready_o SHALL equal rsp_ready_i[head] when FIFO non-empty, else 0.
REQ-028 On response handshake, pop ID FIFO; simultaneous push and pop SHALL keep count unchanged.
REQ-029 Outstanding count SHALL be 0..IdDepth; never exceeds IdDepth; pop on empty never occurs.
REQ-030 slc_out_valid_i while FIFO empty SHALL be ignored (no rsp_valid_o, slc_out_ready_o 0).
REQ-031 flush_i SHALL, next edge, empty FIFO, clear lock; rr_ptr retained; issue/pop in flush cycle discarded.
REQ-032 Zero added latency: issue and response paths purely combinational through held state.
REQ-033 busy_o = (count != 0) | lock.

Reset
REQ-034 rst_ni low SHALL asynchronously clear FIFO, count, lock; rr_ptr <= 0.
REQ-035 During and after reset until first request: slc_valid_o, req_ready_o, rsp_valid_o, slc_out_ready_o, busy_o all 0.
REQ-036 Reset mid-operation SHALL drop all in-flight IDs; late slice results ignored per REQ-030.

Verification
REQ-037 All four requesters valid, slc_ready_i=1 continuously, slice 1-cycle latency -> issue order 0,1,2,3,0; each response on its own rsp_valid_o bit.
REQ-038 Requester 2 granted, slc_ready_i=0 for 3 cycles while requester 0 raises valid -> grant stays 2, payload unchanged, then issues 2 then 3-wrap to 0.
REQ-039 slc_out_ready tied low via rsp_ready_i=0, 4 issues -> 5th blocked (slc_valid_o=0), busy_o=1; one response pop -> next issue proceeds following cycle.
REQ-040 Two in flight (ids 1,3), flush_i pulse -> count 0, busy_o 0, subsequent slc_out_valid_i produces no rsp_valid_o.
REQ-041 Reset asserted with 3 in flight and lock held -> all outputs 0 immediately, rr_ptr 0, first request after release from requester 3 granted.
REQ-042 Full FIFO with pop and pending request same cycle -> no issue that cycle, count IdDepth-1, issue next cycle.

Source files
------------

// File: rtl/fpnew_slice_arbiter.sv
// Round-robin arbiter sharing one FPU format slice among NumReq requesters.
// An in-order ID FIFO routes each slice result back to the requester that issued it.
module fpnew_slice_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned Width       = 32,
  parameter int unsigned NumOperands = 3,
  parameter int unsigned IdDepth     = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq*NumOperands*Width-1:0] req_operands_i,
  input  logic [NumReq*4-1:0]                 req_op_i,
  input  logic [NumReq*3-1:0]                 req_rnd_mode_i,
  output logic                                slc_valid_o,
  input  logic                                slc_ready_i,
  output logic [NumOperands*Width-1:0]        slc_operands_o,
  output logic [3:0]                          slc_op_o,
  output logic [2:0]                          slc_rnd_mode_o,
  input  logic                                slc_out_valid_i,
  output logic                                slc_out_ready_o,
  input  logic [Width-1:0]                    slc_result_i,
  input  logic [4:0]                          slc_status_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  input  logic [NumReq-1:0]                   rsp_ready_i,
  output logic [Width-1:0]                    rsp_result_o,
  output logic [4:0]                          rsp_status_o,
  input  logic                                flush_i,
  output logic                                busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = $clog2(IdDepth);
  localparam int unsigned CntW = $clog2(IdDepth) + 1;
  localparam int unsigned PldW = NumOperands * Width;
  localparam int unsigned OpW  = 4;
  localparam int unsigned RmW  = 3;

  logic [IdxW-1:0] rr_ptr_d, rr_ptr_q, gnt_d, gnt_q;
  logic            lock_d, lock_q;
  logic [IdxW-1:0] fifo_d [IdDepth];
  logic [IdxW-1:0] fifo_q [IdDepth];
  logic [PtrW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0] cnt_d, cnt_q;

  logic [IdxW-1:0] arb_idx_s, cand_s, gnt_s, head_s;
  logic            arb_found_s, full_s, empty_s, issue_s, pop_s;

  // Round-robin search: first valid requester at or after rr_ptr
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = {IdxW{1'b0}};
    cand_s      = {IdxW{1'b0}};
    for (int i = 0; i < int'(NumReq); i++) begin
      cand_s = IdxW'((int'(rr_ptr_q) + i) % int'(NumReq));
      if (!arb_found_s && req_valid_i[cand_s]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = cand_s;
      end else begin
        arb_found_s = arb_found_s;
      end
    end
  end

  assign gnt_s   = lock_q ? gnt_q : arb_idx_s;
  assign full_s  = (cnt_q == CntW'(IdDepth));
  assign empty_s = (cnt_q == {CntW{1'b0}});
  assign head_s  = fifo_q[rd_ptr_q];

  // A full ID FIFO blocks issue even if a response frees a slot this cycle
  assign slc_valid_o    = !full_s && (lock_q || arb_found_s);
  assign issue_s        = slc_valid_o && slc_ready_i;
  assign slc_operands_o = req_operands_i[gnt_s*PldW +: PldW];
  assign slc_op_o       = req_op_i[gnt_s*OpW +: OpW];
  assign slc_rnd_mode_o = req_rnd_mode_i[gnt_s*RmW +: RmW];

  assign slc_out_ready_o = !empty_s && rsp_ready_i[head_s];
  assign pop_s           = slc_out_valid_i && slc_out_ready_o;
  assign rsp_result_o    = slc_result_i;
  assign rsp_status_o    = slc_status_i;
  assign busy_o          = !empty_s || lock_q;

  // One-hot steering of issue accept and response valid
  always_comb begin
    req_ready_o         = {NumReq{1'b0}};
    rsp_valid_o         = {NumReq{1'b0}};
    req_ready_o[gnt_s]  = issue_s;
    rsp_valid_o[head_s] = slc_out_valid_i && !empty_s;
  end

  // Next-state: grant lock, rr pointer and ID FIFO bookkeeping
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    lock_d   = lock_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      lock_d   = 1'b0;
      wr_ptr_d = {PtrW{1'b0}};
      rd_ptr_d = {PtrW{1'b0}};
      cnt_d    = {CntW{1'b0}};
    end else begin
      if (issue_s) begin
        fifo_d[wr_ptr_q] = gnt_s;
        wr_ptr_d         = wr_ptr_q + PtrW'(1);
        lock_d           = 1'b0;
        rr_ptr_d         = (gnt_s == IdxW'(NumReq - 1)) ? {IdxW{1'b0}} : gnt_s + IdxW'(1);
      end else if (slc_valid_o) begin
        lock_d = 1'b1;
        gnt_d  = gnt_s;
      end else begin
        lock_d = lock_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({issue_s, pop_s})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= {IdxW{1'b0}};
      gnt_q    <= {IdxW{1'b0}};
      lock_q   <= 1'b0;
      wr_ptr_q <= {PtrW{1'b0}};
      rd_ptr_q <= {PtrW{1'b0}};
      cnt_q    <= {CntW{1'b0}};
      for (int i = 0; i < int'(IdDepth); i++) begin
        fifo_q[i] <= {IdxW{1'b0}};
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      lock_q   <= lock_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule
